bsg_print_stat_event_buffer: RTL and testbench
==============================================

// Module: bsg_print_stat_event_buffer
// PURPOSE
// - Consumer of the print-stat snoop outputs (print_stat_v/print_stat_tag) in the cosim testbench top.
// - Timestamps each snooped print-stat event with the global cycle counter.
// - Buffers events in a circular FIFO; the DPI host drains it via valid/yumi and attributes stats to kernel phases.
// - Counts events dropped on overflow; never backpressures the snoop, which has no ready.
// PARAMETERS
// - data_width_p       32  width of print_stat tag (= NoC data width)
// - timestamp_width_p  64  width of global cycle counter sample
// - els_p              16  FIFO depth; power of 2, >= 2
// - drop_width_p       16  width of saturating drop counter
// PORTS
// - clk_i             in   1                  core clock
// - reset_n_i         in   1                  reset, asynchronous, active-low
// - print_stat_v_i    in   1                  snooped print-stat event valid (single-cycle pulse)
// - print_stat_tag_i  in   data_width_p       snooped tag
// - ctr_i             in   timestamp_width_p  global cycle counter
// - v_o               out  1                  head entry valid
// - tag_o             out  data_width_p       head tag
// - timestamp_o       out  timestamp_width_p  head timestamp
// - yumi_i            in   1                  host consumes head; legal only when v_o=1
// - count_o           out  clog2(els_p+1)     occupancy
// - overflow_o        out  1                  sticky: >=1 event dropped since reset
// - drop_count_o      out  drop_width_p       dropped events, saturates at all-ones
// BEHAVIOUR
// - Reset (reset_n_i=0, async): rd/wr ptrs=0, count_o=0, v_o=0, overflow_o=0, drop_count_o=0.
// - Reset also clears the capture register. Storage contents are don't-care; tag_o/timestamp_o are X-free only when v_o=1.
// - Capture stage: on print_stat_v_i=1, register {tag, ctr_i} and set cap_v.
//   - Timestamp is ctr_i in the event cycle.
//   - cap_v is a 1-cycle pulse; a new event in the next cycle overwrites it, so back-to-back events are each captured.
// - Enqueue: when cap_v=1, the entry is written at wr_ptr in the cycle after the event.
//   - It is visible on v_o the following cycle: event at T -> v_o at T+2 (FIFO was empty).
// - Full rule: enqueue accepted if count<els_p, or count==els_p and yumi_i=1 in the same cycle.
//   - Otherwise the event is dropped: overflow_o<=1 and drop_count_o increments (saturating).
// - Dequeue: yumi_i=1 with v_o=1 advances rd_ptr; the next head is presented the following cycle.
// - yumi_i with v_o=0 is illegal; assert in simulation, ignored in RTL.
// - Simultaneous enqueue+dequeue: count unchanged; both pointers advance.
// - Enqueue+dequeue with count==1: new entry becomes head next cycle, so v_o stays 1.
// - Pointers are clog2(els_p) bits, wrap modulo els_p. Full/empty come from the count register, not from pointer compare.
// - count_o, v_o (count!=0) and overflow_o are registered outputs. tag_o and timestamp_o read storage at rd_ptr.
// - Reset asserted mid-operation: all buffered and captured events are discarded immediately. No partial entries survive.
// CONFIGURATION
// - Macro BSG_PRINT_STAT_BUFFER_TIMESTAMP_EN.
// - Defined: timestamp column stored per entry; timestamp_o = captured ctr_i.
// - Undefined: no timestamp storage or capture flops; timestamp_o tied to '0.
// - Undefined: ctr_i is unused. Tag and handshake behaviour are identical in both builds.
// TESTING
// - Single event: tag=32'hA5, ctr=100 at T; yumi at first v_o -> v_o at T+2, tag_o=32'hA5, timestamp_o=100, count 1->0.
// - Burst: 16 back-to-back events, els_p=16, no yumi -> count_o=16, overflow_o=0.
//   - 17th event -> overflow_o=1, drop_count_o=1; drain yields tags in order, first..16th.
// - Full+yumi: count=16, event arrives with yumi_i in the enqueue cycle -> accepted, count stays 16, drop_count_o unchanged.
// - Wrap: 40 events interleaved with yumi, max occupancy 3 -> all 40 returned in order, timestamps strictly increasing, no drops.
// - Saturation (drop_width_p=2): 5 events while full -> drop_count_o=3, overflow_o=1.
// - Async reset mid-burst: count=5, reset_n_i low between edges -> v_o=0, count_o=0 immediately.
//   - First post-reset event is returned as the head.
// - Build without TIMESTAMP_EN -> timestamp_o==0 always; tag sequence identical to the timestamped build.

Source files
------------

// File: rtl/bsg_print_stat_event_buffer.sv
// rtl/bsg_print_stat_event_buffer.sv - timestamped print-stat event FIFO with drop counter (option: BSG_PRINT_STAT_BUFFER_TIMESTAMP_EN)
module bsg_print_stat_event_buffer #(
    parameter int data_width_p      = 32,
    parameter int timestamp_width_p = 64,
    parameter int els_p             = 16,
    parameter int drop_width_p      = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             print_stat_v_i,
    input  logic [data_width_p-1:0]          print_stat_tag_i,
    input  logic [timestamp_width_p-1:0]     ctr_i,
    output logic                             v_o,
    output logic [data_width_p-1:0]          tag_o,
    output logic [timestamp_width_p-1:0]     timestamp_o,
    input  logic                             yumi_i,
    output logic [$clog2(els_p+1)-1:0]       count_o,
    output logic                             overflow_o,
    output logic [drop_width_p-1:0]          drop_count_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p+1);

    logic                    cap_v;
    logic [data_width_p-1:0] cap_tag;
    logic [ptr_w-1:0]        rd_ptr;
    logic [ptr_w-1:0]        wr_ptr;
    logic [cnt_w-1:0]        count_r;
    logic [cnt_w-1:0]        count_next;
    logic                    v_r;
    logic                    overflow_r;
    logic [drop_width_p-1:0] drop_r;
    logic                    deq;
    logic                    enq;
    logic                    drop;

    logic [data_width_p-1:0] mem_tag [els_p];

    // A full buffer still accepts when the head leaves in the same cycle.
    assign deq  = yumi_i & v_r;
    assign enq  = cap_v & ((count_r != cnt_w'(els_p)) | deq);
    assign drop = cap_v & ~enq;

    // Occupancy after this cycle's enqueue/dequeue.
    always_comb begin
        count_next = count_r;
        if (enq && !deq)
            count_next = count_r + 1'b1;
        else if (deq && !enq)
            count_next = count_r - 1'b1;
    end

    // Capture stage: one-cycle holding register for the snooped event.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cap_v   <= 1'b0;
            cap_tag <= '0;
        end else begin
            cap_v <= print_stat_v_i;
            if (print_stat_v_i)
                cap_tag <= print_stat_tag_i;
        end
    end

    // Pointer, occupancy and drop bookkeeping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_r    <= '0;
            v_r        <= 1'b0;
            overflow_r <= 1'b0;
            drop_r     <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            count_r <= count_next;
            v_r     <= (count_next != '0);
            if (drop) begin
                overflow_r <= 1'b1;
                if (drop_r != {drop_width_p{1'b1}})
                    drop_r <= drop_r + 1'b1;
            end
        end
    end

    // Tag storage; contents are only meaningful below the occupancy mark.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_tag[wr_ptr] <= cap_tag;
    end

    assign v_o          = v_r;
    assign count_o      = count_r;
    assign overflow_o   = overflow_r;
    assign drop_count_o = drop_r;
    assign tag_o        = mem_tag[rd_ptr];

`ifdef BSG_PRINT_STAT_BUFFER_TIMESTAMP_EN
    logic [timestamp_width_p-1:0] cap_ts;
    logic [timestamp_width_p-1:0] mem_ts [els_p];

    // Timestamp sampled in the event cycle alongside the tag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            cap_ts <= '0;
        else if (print_stat_v_i)
            cap_ts <= ctr_i;
    end

    // Timestamp column written in lockstep with the tag column.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem_ts[wr_ptr] <= cap_ts;
    end

    assign timestamp_o = mem_ts[rd_ptr];
`else
    logic unused_ctr;
    assign unused_ctr  = ^ctr_i;
    assign timestamp_o = '0;
`endif

    yumi_requires_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_print_stat_event_buffer.sv
// tb/tb_bsg_print_stat_event_buffer.sv - self-checking bench for bsg_print_stat_event_buffer
module tb_bsg_print_stat_event_buffer;

    localparam int ELS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev_i;
    logic [31:0] tag_i;
    logic [63:0] ctr_i;
    logic        yumi_i;

    logic        v_o;
    logic [31:0] tag_o;
    logic [63:0] ts_o;
    logic [4:0]  count_o;
    logic        ovf_o;
    logic [15:0] drop_o;

    logic        s_v_o;
    logic [31:0] s_tag_o;
    logic [63:0] s_ts_o;
    logic [4:0]  s_count_o;
    logic        s_ovf_o;
    logic [1:0]  s_drop_o;

    bsg_print_stat_event_buffer dut (
        .clk_i(clk), .reset_n_i(rst_n), .print_stat_v_i(ev_i), .print_stat_tag_i(tag_i),
        .ctr_i(ctr_i), .v_o(v_o), .tag_o(tag_o), .timestamp_o(ts_o), .yumi_i(yumi_i),
        .count_o(count_o), .overflow_o(ovf_o), .drop_count_o(drop_o)
    );

    bsg_print_stat_event_buffer #(.drop_width_p(2)) dut_sat (
        .clk_i(clk), .reset_n_i(rst_n), .print_stat_v_i(ev_i), .print_stat_tag_i(tag_i),
        .ctr_i(ctr_i), .v_o(s_v_o), .tag_o(s_tag_o), .timestamp_o(s_ts_o), .yumi_i(yumi_i),
        .count_o(s_count_o), .overflow_o(s_ovf_o), .drop_count_o(s_drop_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: queue of accepted events plus the one in flight
    logic [31:0] q_tag [$];
    logic [63:0] q_ts  [$];
    bit          pend_v;
    logic [31:0] pend_tag;
    logic [63:0] pend_ts;
    bit          m_ovf;
    int          m_drops;
    longint      ctr_next;

    typedef struct {
        logic        ev;
        logic [31:0] tag;
        logic        yumi;
        int          exp_count;
        logic        exp_v;
        logic [31:0] exp_tag;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_ts(input logic [63:0] t);
`ifdef BSG_PRINT_STAT_BUFFER_TIMESTAMP_EN
        return t;
`else
        return 64'd0 & t;
`endif
    endfunction

    task automatic check_model();
        chk("count", 64'(count_o), 64'(q_tag.size()));
        chk("v", 64'(v_o), 64'(q_tag.size() != 0));
        chk("overflow", 64'(ovf_o), 64'(m_ovf));
        chk("drop_count", 64'(drop_o), 64'((m_drops > 65535) ? 65535 : m_drops));
        chk("sat_drop_count", 64'(s_drop_o), 64'((m_drops > 3) ? 3 : m_drops));
        chk("sat_overflow", 64'(s_ovf_o), 64'(m_ovf));
        if (q_tag.size() != 0) begin
            chk("head_tag", 64'(tag_o), 64'(q_tag[0]));
            chk("head_ts", ts_o, exp_ts(q_ts[0]));
        end
`ifndef BSG_PRINT_STAT_BUFFER_TIMESTAMP_EN
        chk("ts_zero", ts_o, 64'd0);
`endif
    endtask

    // called at a negedge: drive, clock once, advance model, check at next negedge
    task automatic cycle(input logic ev, input logic [31:0] tag, input logic yumi);
        ev_i   = ev;
        tag_i  = tag;
        yumi_i = yumi;
        ctr_i  = 64'(ctr_next);
        ctr_next++;
        @(posedge clk);
        if (yumi && q_tag.size() != 0) begin
            void'(q_tag.pop_front());
            void'(q_ts.pop_front());
        end
        if (pend_v) begin
            if (q_tag.size() < ELS) begin
                q_tag.push_back(pend_tag);
                q_ts.push_back(pend_ts);
            end else begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end
        pend_v   = ev;
        pend_tag = tag;
        pend_ts  = ctr_i;
        @(negedge clk);
        check_model();
    endtask

    task automatic model_reset();
        q_tag.delete();
        q_ts.delete();
        pend_v  = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q_tag.size() != 0 || pend_v) && guard < 64) begin
            cycle(1'b0, 32'd0, q_tag.size() != 0);
            guard++;
        end
        chk("drain_empty", 64'(q_tag.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [3];
        int   sent, returned, guard, drops_before;
        logic [63:0] last_ts;

        rst_n  = 1'b0;
        ev_i   = 1'b0;
        tag_i  = '0;
        ctr_i  = '0;
        yumi_i = 1'b0;
        ctr_next = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_model();

        // single event: v_o two cycles after the event, then consumed
        tbl[0] = '{1'b1, 32'hA5, 1'b0, 0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0,  1'b0, 1, 1'b1, 32'hA5};
        tbl[2] = '{1'b0, 32'h0,  1'b1, 0, 1'b0, 32'h0};
        ctr_next = 100;
        for (int i = 0; i < 3; i++) begin
            cycle(tbl[i].ev, tbl[i].tag, tbl[i].yumi);
            chk("tbl_count", 64'(count_o), 64'(tbl[i].exp_count));
            chk("tbl_v", 64'(v_o), 64'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk("tbl_tag", 64'(tag_o), 64'(tbl[i].exp_tag));
                chk("tbl_ts", ts_o, exp_ts(64'd100));
            end
        end

        // burst of 17: sixteen fill the buffer, the 17th is dropped
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b0);
            if (i == 16) begin
                chk("burst_full", 64'(count_o), 64'd16);
                chk("burst_no_ovf", 64'(ovf_o), 64'd0);
            end
        end
        cycle(1'b0, 32'd0, 1'b0);
        chk("burst_ovf", 64'(ovf_o), 64'd1);
        chk("burst_drop", 64'(drop_o), 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk("burst_order", 64'(tag_o), 64'(32'h100 + 32'(i)));
            cycle(1'b0, 32'd0, 1'b1);
        end
        chk("burst_empty", 64'(v_o), 64'd0);

        // full buffer with yumi in the enqueue cycle accepts the event
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 32'h200 + 32'(i), 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h777, 1'b0);
        cycle(1'b0, 32'd0, 1'b1);
        chk("fullyumi_count", 64'(count_o), 64'd16);
        chk("fullyumi_drop", 64'(drop_o), 64'd1);
        drain();

        // wrap: 40 events, occupancy kept at 3 or below
        sent = 0; returned = 0; guard = 0; last_ts = 0;
        drops_before = m_drops;
        while (returned < 40 && guard < 1000) begin
            logic ev, y;
            ev = (sent < 40) && ((q_tag.size() + int'(pend_v)) < 3) && ($urandom_range(0, 1) == 1);
            y  = (q_tag.size() != 0) && ($urandom_range(0, 2) != 0);
            if (y) begin
                chk("wrap_order", 64'(tag_o), 64'(32'h1000 + 32'(returned)));
`ifdef BSG_PRINT_STAT_BUFFER_TIMESTAMP_EN
                if (returned > 0)
                    chk("wrap_ts_incr", 64'(ts_o > last_ts), 64'd1);
                last_ts = ts_o;
`endif
                returned++;
            end
            cycle(ev, 32'h1000 + 32'(sent), y);
            if (ev) sent++;
            guard++;
        end
        chk("wrap_returned", 64'(returned), 64'd40);
        chk("wrap_no_drop", 64'(drop_o), 64'(drops_before));

        // randomized traffic against the queue model, including overflow
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(0, 9) < 7, $urandom, (q_tag.size() != 0) && ($urandom_range(0, 9) < 4));
        drain();

        // asynchronous reset mid-burst
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h300 + 32'(i), 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        chk("pre_reset_count", 64'(count_o), 64'd5);
        ev_i = 1'b1;
        tag_i = 32'h3FF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_v", 64'(v_o), 64'd0);
        chk("async_count", 64'(count_o), 64'd0);
        chk("async_ovf", 64'(ovf_o), 64'd0);
        chk("async_drop", 64'(drop_o), 64'd0);
        ev_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 32'hBEEF, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        chk("post_reset_head", 64'(tag_o), 64'hBEEF);
        chk("post_reset_count", 64'(count_o), 64'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
